rs_wakeup_queue: RTL and testbench

- Multi-entry, parametrised reservation station for one functional-unit class (ALU, MUL/DIV or branch); one instance per class.
- Buffers dispatched ops until both source operands are captured, then issues the oldest ready entry to its execute unit over a valid/ready handshake.
- Operand wakeup is tag-based (ROB index) from NUM_CDB broadcast channels, with same-cycle capture at dispatch; pipeline flush clears all entries.

---
 rtl/rs_wakeup_queue_if.sv | 50 +++++
 rtl/rs_wakeup_queue.sv | 170 +++++++++++++++++
 tb/tb_rs_wakeup_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_wakeup_queue_if.sv
// Dispatch / CDB / issue bundle of one reservation station; the station is the slave.
interface rs_wakeup_queue_if #(
  parameter int DEPTH         = 4,
  parameter int NUM_CDB       = 3,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 128
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                             flush;
  logic                             dispatch_valid;
  logic                             dispatch_ready;
  logic [PAYLOAD_WIDTH-1:0]         dispatch_payload;
  logic [ROB_IDX_WIDTH-1:0]         dispatch_rd_rob_idx;
  logic                             dispatch_rs1_ready;
  logic                             dispatch_rs2_ready;
  logic [DATA_WIDTH-1:0]            dispatch_rs1_data;
  logic [DATA_WIDTH-1:0]            dispatch_rs2_data;
  logic [ROB_IDX_WIDTH-1:0]         dispatch_rs1_rob_idx;
  logic [ROB_IDX_WIDTH-1:0]         dispatch_rs2_rob_idx;
  logic [NUM_CDB-1:0]               cdb_valid;
  logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_rob_idx;
  logic [NUM_CDB*DATA_WIDTH-1:0]    cdb_data;
  logic                             issue_valid;
  logic                             issue_ready;
  logic [PAYLOAD_WIDTH-1:0]         issue_payload;
  logic [ROB_IDX_WIDTH-1:0]         issue_rd_rob_idx;
  logic [DATA_WIDTH-1:0]            issue_rs1_data;
  logic [DATA_WIDTH-1:0]            issue_rs2_data;
  logic [OCC_W-1:0]                 occupancy;

  modport master (
    output flush, dispatch_valid, dispatch_payload, dispatch_rd_rob_idx,
           dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_data, dispatch_rs2_data,
           dispatch_rs1_rob_idx, dispatch_rs2_rob_idx, cdb_valid, cdb_rob_idx, cdb_data,
           issue_ready,
    input  dispatch_ready, issue_valid, issue_payload, issue_rd_rob_idx,
           issue_rs1_data, issue_rs2_data, occupancy
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_payload, dispatch_rd_rob_idx,
           dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_data, dispatch_rs2_data,
           dispatch_rs1_rob_idx, dispatch_rs2_rob_idx, cdb_valid, cdb_rob_idx, cdb_data,
           issue_ready,
    output dispatch_ready, issue_valid, issue_payload, issue_rd_rob_idx,
           issue_rs1_data, issue_rs2_data, occupancy
  );
endinterface

// File: rtl/rs_wakeup_queue.sv
// Reservation station: tag wakeup from the CDBs, oldest-ready issue; issue one cycle after ready.
// Backpressure: dispatch_ready drops when full; an unaccepted issue stays until taken or overtaken by an older op.
module rs_wakeup_queue #(
  parameter int DEPTH         = 4,
  parameter int NUM_CDB       = 3,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  rs_wakeup_queue_if.slave io
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [ROB_IDX_WIDTH-1:0] rd;
    logic                     rs1_rdy;
    logic [ROB_IDX_WIDTH-1:0] rs1_tag;
    logic [DATA_WIDTH-1:0]    rs1_dat;
    logic                     rs2_rdy;
    logic [ROB_IDX_WIDTH-1:0] rs2_tag;
    logic [DATA_WIDTH-1:0]    rs2_dat;
  } ent_t;

  ent_t             r_ent   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  // r_older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic                  w_dsp_fire;
  logic                  w_iss_fire;
  logic [IDX_W-1:0]      w_alloc_idx;
  logic [DEPTH-1:0]      w_alloc_oh;
  logic [DEPTH-1:0]      w_elig;
  logic [DEPTH-1:0]      w_sel;
  logic [DEPTH-1:0]      w_vld_nxt;
  logic [DEPTH-1:0]      w_wk1_hit;
  logic [DEPTH-1:0]      w_wk2_hit;
  logic [DATA_WIDTH-1:0] w_wk1_dat [DEPTH];
  logic [DATA_WIDTH-1:0] w_wk2_dat [DEPTH];
  ent_t                  w_new;
  ent_t                  w_iss;

  assign io.dispatch_ready = (r_occ < OCC_W'(DEPTH));
  assign w_dsp_fire        = io.dispatch_valid && io.dispatch_ready;
  assign w_iss_fire        = io.issue_valid && io.issue_ready;

  always_comb begin
    w_alloc_idx = '0;
    w_alloc_oh  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_alloc_idx = IDX_W'(i);
    end
    w_alloc_oh[w_alloc_idx] = 1'b1;
  end

  // Descending channel scan leaves the lowest matching channel as the winner
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1_hit[i] = 1'b0;
      w_wk2_hit[i] = 1'b0;
      w_wk1_dat[i] = '0;
      w_wk2_dat[i] = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (io.cdb_valid[k] && io.cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == r_ent[i].rs1_tag) begin
          w_wk1_hit[i] = 1'b1;
          w_wk1_dat[i] = io.cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (io.cdb_valid[k] && io.cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == r_ent[i].rs2_tag) begin
          w_wk2_hit[i] = 1'b1;
          w_wk2_dat[i] = io.cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    w_new         = '0;
    w_new.payload = io.dispatch_payload;
    w_new.rd      = io.dispatch_rd_rob_idx;
    w_new.rs1_rdy = io.dispatch_rs1_ready;
    w_new.rs1_tag = io.dispatch_rs1_rob_idx;
    w_new.rs1_dat = io.dispatch_rs1_data;
    w_new.rs2_rdy = io.dispatch_rs2_ready;
    w_new.rs2_tag = io.dispatch_rs2_rob_idx;
    w_new.rs2_dat = io.dispatch_rs2_data;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (!io.dispatch_rs1_ready && io.cdb_valid[k] &&
          io.cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == io.dispatch_rs1_rob_idx) begin
        w_new.rs1_rdy = 1'b1;
        w_new.rs1_dat = io.cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (!io.dispatch_rs2_ready && io.cdb_valid[k] &&
          io.cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == io.dispatch_rs2_rob_idx) begin
        w_new.rs2_rdy = 1'b1;
        w_new.rs2_dat = io.cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i] = r_vld[i] && r_ent[i].rs1_rdy && r_ent[i].rs2_rdy;
    end
  end

  always_comb begin
    w_sel = '0;
    w_iss = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && w_elig[j] && r_older[j][i]) w_sel[i] = 1'b0;
      end
      if (w_sel[i]) w_iss = r_ent[i];
    end
  end

  assign io.issue_valid      = |w_sel;
  assign io.issue_payload    = w_iss.payload;
  assign io.issue_rd_rob_idx = w_iss.rd;
  assign io.issue_rs1_data   = w_iss.rs1_dat;
  assign io.issue_rs2_data   = w_iss.rs2_dat;
  assign io.occupancy        = r_occ;

  assign w_vld_nxt = (r_vld & ~(w_iss_fire ? w_sel : '0)) | (w_dsp_fire ? w_alloc_oh : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i]   <= '0;
        r_older[i] <= '0;
      end
    end else if (io.flush) begin
      r_vld <= '0;
      r_occ <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      case ({w_dsp_fire, w_iss_fire})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && !r_ent[i].rs1_rdy && w_wk1_hit[i]) begin
          r_ent[i].rs1_rdy <= 1'b1;
          r_ent[i].rs1_dat <= w_wk1_dat[i];
        end
        if (r_vld[i] && !r_ent[i].rs2_rdy && w_wk2_hit[i]) begin
          r_ent[i].rs2_rdy <= 1'b1;
          r_ent[i].rs2_dat <= w_wk2_dat[i];
        end
      end
      // New entry is younger than everything: clear its row, set its column
      if (w_dsp_fire) begin
        r_ent[w_alloc_idx]   <= w_new;
        r_older[w_alloc_idx] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) != w_alloc_idx) r_older[j][w_alloc_idx] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_wakeup_queue.sv
// Directed bench for rs_wakeup_queue: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_rs_wakeup_queue;
  localparam int DEPTH = 4;
  localparam int NCDB  = 3;
  localparam int TW    = 5;
  localparam int DW    = 32;
  localparam int PW    = 128;

  typedef struct packed {
    logic [PW-1:0] pl;
    logic [TW-1:0] rd;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  rs_wakeup_queue_if #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .ROB_IDX_WIDTH(TW),
                       .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) bus ();

  rs_wakeup_queue #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .ROB_IDX_WIDTH(TW),
                    .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush                = 1'b0;
    bus.dispatch_valid       = 1'b0;
    bus.dispatch_payload     = '0;
    bus.dispatch_rd_rob_idx  = '0;
    bus.dispatch_rs1_ready   = 1'b0;
    bus.dispatch_rs2_ready   = 1'b0;
    bus.dispatch_rs1_data    = '0;
    bus.dispatch_rs2_data    = '0;
    bus.dispatch_rs1_rob_idx = '0;
    bus.dispatch_rs2_rob_idx = '0;
    bus.cdb_valid            = '0;
    bus.cdb_rob_idx          = '0;
    bus.cdb_data             = '0;
  endtask

  task automatic cdb(input int ch, input logic [TW-1:0] tag, input logic [DW-1:0] dat);
    bus.cdb_valid[ch]                = 1'b1;
    bus.cdb_rob_idx[ch*TW +: TW]     = tag;
    bus.cdb_data[ch*DW +: DW]        = dat;
  endtask

  // Drives one dispatch for a cycle; caller sets any same-cycle CDB traffic beforehand
  task automatic dispatch(input logic [PW-1:0] pl, input logic [TW-1:0] rd,
                          input logic r1, input logic [DW-1:0] d1, input logic [TW-1:0] t1,
                          input logic r2, input logic [DW-1:0] d2, input logic [TW-1:0] t2);
    bus.dispatch_valid       = 1'b1;
    bus.dispatch_payload     = pl;
    bus.dispatch_rd_rob_idx  = rd;
    bus.dispatch_rs1_ready   = r1;
    bus.dispatch_rs1_data    = d1;
    bus.dispatch_rs1_rob_idx = t1;
    bus.dispatch_rs2_ready   = r2;
    bus.dispatch_rs2_data    = d2;
    bus.dispatch_rs2_rob_idx = t2;
    step();
    idle();
  endtask

  task automatic expect_issue(input logic [PW-1:0] pl, input logic [TW-1:0] rd,
                              input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.pl = pl; e.rd = rd; e.rs1 = a; e.rs2 = b;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted issue must match the head of the expected queue
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (!rst && !bus.flush && bus.issue_valid && bus.issue_ready) begin
        a.pl = bus.issue_payload; a.rd = bus.issue_rd_rob_idx;
        a.rs1 = bus.issue_rs1_data; a.rs2 = bus.issue_rs2_data;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL issue_unexpected: got %0h, expected no issue", a);
        end else begin
          e = exp_q.pop_front();
          check("issue_op", 256'(a), 256'(e));
        end
      end
    end
  end

  initial begin
    idle();
    bus.issue_ready = 1'b0;
    #23;
    check("rst_occ", 256'(bus.occupancy), 256'(0));
    check("rst_dready", 256'(bus.dispatch_ready), 256'(1));
    check("rst_ivalid", 256'(bus.issue_valid), 256'(0));
    rst = 1'b0;
    step();
    check("post_rst_payload", 256'(bus.issue_payload), 256'(0));

    // Both operands ready at dispatch
    bus.issue_ready = 1'b1;
    expect_issue(128'h1, 5'd3, 32'h5, 32'h7);
    check("t1_occ_before", 256'(bus.occupancy), 256'(0));
    dispatch(128'h1, 5'd3, 1'b1, 32'h5, 5'd0, 1'b1, 32'h7, 5'd0);
    check("t1_ivalid", 256'(bus.issue_valid), 256'(1));
    check("t1_occ_one", 256'(bus.occupancy), 256'(1));
    step();
    check("t1_occ_zero", 256'(bus.occupancy), 256'(0));

    // Wakeup on CDB channel 2
    expect_issue(128'h2, 5'd6, 32'hDEADBEEF, 32'h22);
    dispatch(128'h2, 5'd6, 1'b0, 32'h0, 5'd9, 1'b1, 32'h22, 5'd0);
    check("t2_wait_a", 256'(bus.issue_valid), 256'(0));
    step();
    check("t2_wait_b", 256'(bus.issue_valid), 256'(0));
    cdb(2, 5'd9, 32'hDEADBEEF);
    #1;
    check("t2_wake_not_comb", 256'(bus.issue_valid), 256'(0));
    step();
    idle();
    check("t2_ivalid", 256'(bus.issue_valid), 256'(1));
    check("t2_rs1", 256'(bus.issue_rs1_data), 256'(32'hDEADBEEF));
    step();
    check("t2_occ", 256'(bus.occupancy), 256'(0));

    // Capture from CDB channel 0 in the dispatch cycle
    expect_issue(128'h3, 5'd7, 32'h33, 32'h11);
    cdb(0, 5'd4, 32'h11);
    dispatch(128'h3, 5'd7, 1'b1, 32'h33, 5'd0, 1'b0, 32'h0, 5'd4);
    check("t3_ivalid", 256'(bus.issue_valid), 256'(1));
    check("t3_rs2", 256'(bus.issue_rs2_data), 256'(32'h11));
    step();
    check("t3_occ", 256'(bus.occupancy), 256'(0));

    // Age order under backpressure
    bus.issue_ready = 1'b0;
    expect_issue(128'hA, 5'd1, 32'hAAAA, 32'hA2);
    expect_issue(128'hB, 5'd2, 32'hB1, 32'hB2);
    expect_issue(128'hC, 5'd3, 32'hC1, 32'hC2);
    dispatch(128'hA, 5'd1, 1'b0, 32'h0, 5'd12, 1'b1, 32'hA2, 5'd0);
    dispatch(128'hB, 5'd2, 1'b1, 32'hB1, 5'd0, 1'b1, 32'hB2, 5'd0);
    dispatch(128'hC, 5'd3, 1'b1, 32'hC1, 5'd0, 1'b1, 32'hC2, 5'd0);
    check("t4_occ3", 256'(bus.occupancy), 256'(3));
    check("t4_present_b", 256'(bus.issue_payload), 256'(128'hB));
    cdb(1, 5'd12, 32'hAAAA);
    step();
    idle();
    check("t4_present_a", 256'(bus.issue_payload), 256'(128'hA));
    bus.issue_ready = 1'b1;
    step();
    step();
    step();
    check("t4_occ0", 256'(bus.occupancy), 256'(0));
    check("t4_drained", 256'(bus.issue_valid), 256'(0));

    // Full, ignored fifth dispatch, then flush racing a dispatch
    bus.issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(PW'(32'h100 + i), TW'(i), 1'b0, 32'h0, TW'(20 + i), 1'b1, 32'h0, 5'd0);
    end
    check("t5_full_occ", 256'(bus.occupancy), 256'(4));
    check("t5_full_dready", 256'(bus.dispatch_ready), 256'(0));
    dispatch(128'h105, 5'd5, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    check("t5_fifth_ignored", 256'(bus.occupancy), 256'(4));
    check("t5_no_issue", 256'(bus.issue_valid), 256'(0));
    bus.flush = 1'b1;
    dispatch(128'h106, 5'd6, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    check("t5_flush_occ", 256'(bus.occupancy), 256'(0));
    check("t5_flush_ivalid", 256'(bus.issue_valid), 256'(0));
    check("t5_flush_dready", 256'(bus.dispatch_ready), 256'(1));
    cdb(0, 5'd20, 32'h5);
    step();
    idle();
    check("t5_stale_no_wake", 256'(bus.issue_valid), 256'(0));

    // Asynchronous reset between edges with live entries
    for (int i = 0; i < 3; i++) begin
      dispatch(PW'(32'h200 + i), TW'(i), 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    end
    check("t6_occ3", 256'(bus.occupancy), 256'(3));
    check("t6_ivalid", 256'(bus.issue_valid), 256'(1));
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_occ", 256'(bus.occupancy), 256'(0));
    check("t6_arst_ivalid", 256'(bus.issue_valid), 256'(0));
    check("t6_arst_dready", 256'(bus.dispatch_ready), 256'(1));
    check("t6_arst_payload", 256'(bus.issue_payload), 256'(0));
    #3;
    rst = 1'b0;
    step();

    // Recovery after reset
    bus.issue_ready = 1'b1;
    expect_issue(128'h300, 5'd9, 32'h99, 32'h98);
    dispatch(128'h300, 5'd9, 1'b1, 32'h99, 5'd0, 1'b1, 32'h98, 5'd0);
    step();
    check("t7_occ", 256'(bus.occupancy), 256'(0));
    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
